// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: 2-flop sync, stability counter, press/release/long strobes.
// Optional auto-repeat strobes when KEY_REPEAT_EN is defined; otherwise key_repeat is tied low.
module key_debounce_multi #(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int REPEAT_CYCLES     = 10000000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                key_any
);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

    if (NUM_KEYS < 1 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 2)
    begin : g_bad_params
        $error("key_debounce_multi: parameter out of range");
    end

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] long_q, long_d;
    logic                any_q, any_d;
    logic [DEB_W-1:0]    deb_q  [NUM_KEYS];
    logic [DEB_W-1:0]    deb_d  [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_q [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_d [NUM_KEYS];

    always_comb begin
        sync1_d   = key_in;
        sync2_d   = sync1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            deb_d[i]  = '0;
            hold_d[i] = hold_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (deb_q[i] == DEB_LAST) begin
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = ~sync2_q[i];
                    release_d[i] = sync2_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + 1'b1;
                end
            end
            // Saturating at LONG_PRESS_CYCLES makes the long strobe one-shot per press.
            if (level_q[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] != HOLD_SAT) begin
                hold_d[i] = hold_q[i] + 1'b1;
            end
            long_d[i] = ~level_q[i] && (hold_q[i] == HOLD_FIRE) && ~release_d[i];
        end
        any_d = |press_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                deb_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            any_q     <= any_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                deb_q[i]  <= deb_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int                REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [NUM_KEYS-1:0] repeat_q, repeat_d;
    logic [REP_W-1:0]    rep_q [NUM_KEYS];
    logic [REP_W-1:0]    rep_d [NUM_KEYS];

    // Counting starts once hold_cnt has saturated, i.e. the cycle key_long is visible.
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            rep_d[i] = rep_q[i];
            if (level_q[i] || release_d[i] || long_d[i]) begin
                rep_d[i] = '0;
            end else if (hold_q[i] == HOLD_SAT) begin
                if (rep_q[i] == REP_LAST) begin
                    rep_d[i]    = '0;
                    repeat_d[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            repeat_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                rep_q[i] <= '0;
            end
        end else begin
            repeat_q <= repeat_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                rep_q[i] <= rep_d[i];
            end
        end
    end

    assign key_repeat = repeat_q;
`else
    assign key_repeat = '0;
`endif

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_any     = any_q;

endmodule
